fe_packer: RTL and testbench

Downstream of the front-end capture stage in the `fe_clk` domain. Accepts one event per cycle (DATA, STAT or TIME command with timestamp, data and status) and packs it into a single 18-bit word for the front-end FIFO. A small elastic buffer absorbs FIFO-full stalls, because the capture stage cannot be back-pressured. Buffer overflow is counted and reported in-band with a MARK word and through a sticky flag.

---
 rtl/fe_packer_if.sv | 28 ++
 rtl/fe_packer.sv | 164 ++++++++++++++++
 tb/tb_fe_packer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fe_packer_if.sv
// Event-in / FIFO-out bus of fe_packer. The capture stage drives the I_* signals
// and the packer drives the O_* signals toward the front-end FIFO.
interface fe_packer_if;
    logic        I_capture_enable;
    logic        I_clear_flags;
    logic [1:0]  I_command;
    logic [15:0] I_time;
    logic [7:0]  I_data;
    logic [4:0]  I_status;
    logic        I_data_wr;
    logic        I_fifo_full;
    logic        O_fifo_wr;
    logic [17:0] O_fifo_din;
    logic        O_overflow;
    logic [15:0] O_word_count;

    modport slave (
        input  I_capture_enable, I_clear_flags, I_command, I_time, I_data,
               I_status, I_data_wr, I_fifo_full,
        output O_fifo_wr, O_fifo_din, O_overflow, O_word_count
    );

    modport master (
        output I_capture_enable, I_clear_flags, I_command, I_time, I_data,
               I_status, I_data_wr, I_fifo_full,
        input  O_fifo_wr, O_fifo_din, O_overflow, O_word_count
    );
endinterface

// File: rtl/fe_packer.sv
// Packs capture events into 18-bit FIFO words through a small elastic buffer.
// Define FE_PACKER_MARK_EN to report dropped events in-band with a MARK word.
module fe_packer #(
    parameter int unsigned pDEPTH      = 4,
    parameter int unsigned pDROP_WIDTH = 16
) (
    input  logic       fe_clk,
    input  logic       reset_i,
    fe_packer_if.slave bus
);
    localparam int unsigned cPTR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
    localparam int unsigned cCNT_W = cPTR_W + 1;

    localparam logic [1:0] cCMD_TIME   = 2'b10;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_OVERFLOW = 2'd2;
`ifdef FE_PACKER_MARK_EN
    localparam logic [1:0] ST_MARK     = 2'd3;
    localparam logic [1:0] cCMD_MARK   = 2'b11;
`endif

    if ((pDEPTH < 2) || ((pDEPTH & (pDEPTH - 1)) != 0) ||
        (pDROP_WIDTH < 1) || (pDROP_WIDTH > 16)) begin : g_param_check
        $error("fe_packer: pDEPTH must be a power of two >= 2 and pDROP_WIDTH in 1..16");
    end

    logic [17:0]       r_mem [pDEPTH];
    logic [cPTR_W-1:0] r_wr_ptr;
    logic [cPTR_W-1:0] r_rd_ptr;
    logic [cCNT_W-1:0] r_count;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_fifo_wr;
    logic [17:0]       r_fifo_din;
    logic              r_overflow;
    logic [15:0]       r_word_count;

    logic              w_event;
    logic              w_empty;
    logic              w_pop;
    logic              w_space;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_wr_nxt;
    logic [17:0]       w_word;

    assign w_event   = bus.I_data_wr && bus.I_capture_enable;
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && !bus.I_fifo_full;
    // A full buffer still accepts an event when a word leaves in the same cycle.
    assign w_space   = (r_count < cCNT_W'(pDEPTH)) || w_pop;
    assign w_push    = w_event && (r_state == ST_RUN) && w_space;
    assign w_ovf_set = w_event && (r_state == ST_RUN) && !w_space;

    assign w_word = (bus.I_command == cCMD_TIME) ?
                    {bus.I_command, bus.I_time} :
                    {bus.I_command, bus.I_status, bus.I_data, bus.I_time[2:0]};

`ifdef FE_PACKER_MARK_EN
    logic [pDROP_WIDTH-1:0] r_drop_cnt;
    logic [pDROP_WIDTH-1:0] w_drop_inc;
    logic [pDROP_WIDTH-1:0] w_mark_cnt;
    logic                   w_mark_wr;

    assign w_drop_inc = (r_drop_cnt == '1) ? r_drop_cnt : r_drop_cnt + pDROP_WIDTH'(1);
    // An event dropped in the same cycle as the MARK write is included in its payload.
    assign w_mark_cnt = w_event ? w_drop_inc : r_drop_cnt;
    assign w_mark_wr  = (r_state == ST_MARK) && !bus.I_fifo_full;
    assign w_wr_nxt   = w_pop || w_mark_wr;

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            r_drop_cnt <= '0;
        end else if (w_mark_wr) begin
            r_drop_cnt <= '0;
        end else if (w_ovf_set) begin
            r_drop_cnt <= pDROP_WIDTH'(1);
        end else if (w_event && ((r_state == ST_OVERFLOW) || (r_state == ST_MARK))) begin
            r_drop_cnt <= w_drop_inc;
        end
    end
`else
    assign w_wr_nxt = w_pop;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.I_capture_enable) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_ovf_set)                  w_state_nxt = ST_OVERFLOW;
                else if (!bus.I_capture_enable) w_state_nxt = ST_IDLE;
            end
            ST_OVERFLOW: begin
`ifdef FE_PACKER_MARK_EN
                if (w_empty && !bus.I_fifo_full) w_state_nxt = ST_MARK;
`else
                if (w_empty) w_state_nxt = bus.I_capture_enable ? ST_RUN : ST_IDLE;
`endif
            end
`ifdef FE_PACKER_MARK_EN
            ST_MARK: begin
                if (!bus.I_fifo_full) w_state_nxt = bus.I_capture_enable ? ST_RUN : ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + cPTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + cPTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cCNT_W'(1);
                2'b01:   r_count <= r_count - cCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge fe_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            r_fifo_wr    <= 1'b0;
            r_fifo_din   <= '0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_fifo_wr <= w_wr_nxt;
            if (w_pop) begin
                r_fifo_din <= r_mem[r_rd_ptr];
            end
`ifdef FE_PACKER_MARK_EN
            else if (w_mark_wr) begin
                r_fifo_din <= {cCMD_MARK, 16'(w_mark_cnt)};
            end
`endif
            if (bus.I_clear_flags)  r_overflow <= 1'b0;
            else if (w_ovf_set)     r_overflow <= 1'b1;
            if (bus.I_clear_flags)
                r_word_count <= '0;
            else if (w_wr_nxt && (r_word_count != '1))
                r_word_count <= r_word_count + 16'd1;
        end
    end

    assign bus.O_fifo_wr    = r_fifo_wr;
    assign bus.O_fifo_din   = r_fifo_din;
    assign bus.O_overflow   = r_overflow;
    assign bus.O_word_count = r_word_count;
endmodule

// File: tb/tb_fe_packer.sv
// Directed bench for fe_packer: latency, packing, overflow/MARK, same-cycle
// push/pop at full, flag clear priority and mid-stream reset.
module tb_fe_packer;
    logic        fe_clk = 1'b0;
    logic        reset_i;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [17:0] q_words[$];
    logic        r_full_at_edge = 1'b0;

`ifdef FE_PACKER_MARK_EN
    localparam int cMARK_WORDS = 1;
`else
    localparam int cMARK_WORDS = 0;
`endif

    fe_packer_if bus();

    fe_packer #(
        .pDEPTH      (4),
        .pDROP_WIDTH (16)
    ) dut (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge fe_clk) r_full_at_edge <= bus.I_fifo_full;

    always @(negedge fe_clk) begin
        if (bus.O_fifo_wr === 1'b1) begin
            q_words.push_back(bus.O_fifo_din);
            check_val("wr_while_full", {31'd0, r_full_at_edge}, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge fe_clk);
    endtask

    task automatic send(input logic [1:0] cmd, input logic [15:0] t,
                        input logic [7:0] d, input logic [4:0] s);
        bus.I_command = cmd;
        bus.I_time    = t;
        bus.I_data    = d;
        bus.I_status  = s;
        bus.I_data_wr = 1'b1;
        @(negedge fe_clk);
        bus.I_data_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        reset_i              = 1'b1;
        bus.I_capture_enable = 1'b0;
        bus.I_clear_flags    = 1'b0;
        bus.I_command        = 2'b00;
        bus.I_time           = '0;
        bus.I_data           = '0;
        bus.I_status         = '0;
        bus.I_data_wr        = 1'b0;
        bus.I_fifo_full      = 1'b0;
        step(2);
        check_val("rst_wr",    bus.O_fifo_wr,    0);
        check_val("rst_din",   bus.O_fifo_din,   0);
        check_val("rst_ovf",   bus.O_overflow,   0);
        check_val("rst_count", bus.O_word_count, 0);
        reset_i              = 1'b0;
        bus.I_capture_enable = 1'b1;
        step(1);

        // single DATA event: time 5, data A5, status 11
        send(2'b00, 16'd5, 8'hA5, 5'h11);
        check_val("t1_wr_early", bus.O_fifo_wr, 0);
        step(1);
        check_val("t1_wr",   bus.O_fifo_wr,  1);
        check_val("t1_din",  bus.O_fifo_din, 18'h08D2D);
        step(1);
        check_val("t1_wr_pulse", bus.O_fifo_wr,    0);
        check_val("t1_din_hold", bus.O_fifo_din,   18'h08D2D);
        check_val("t1_count",    bus.O_word_count, 1);

        // TIME event
        send(2'b10, 16'hBEEF, 8'h00, 5'h00);
        step(1);
        check_val("t2_wr",  bus.O_fifo_wr,  1);
        check_val("t2_din", bus.O_fifo_din, 18'h2BEEF);
        step(1);
        check_val("t2_count", bus.O_word_count, 2);

        // 7 events against a full FIFO held 10 cycles
        q_words.delete();
        bus.I_fifo_full = 1'b1;
        for (int i = 1; i <= 7; i++) send(2'b00, 16'(i), 8'(i), 5'd0);
        step(3);
        check_val("t3_ovf",      bus.O_overflow,   1);
        check_val("t3_no_write", bus.O_word_count, 2);
        bus.I_fifo_full = 1'b0;
        step(12);
        check_val("t3_nwords", q_words.size(), 4 + cMARK_WORDS);
        check_val("t3_w0",     q_words[0], 18'h00009);
        check_val("t3_w3",     q_words[3], 18'h00024);
`ifdef FE_PACKER_MARK_EN
        check_val("t3_mark",   q_words[4], 18'h30003);
`endif
        check_val("t3_count",  bus.O_word_count, 6 + cMARK_WORDS);

        // clear alone, then push+pop at a full buffer
        bus.I_clear_flags = 1'b1;
        step(1);
        bus.I_clear_flags = 1'b0;
        check_val("t4_clr_ovf",   bus.O_overflow,   0);
        check_val("t4_clr_count", bus.O_word_count, 0);
        q_words.delete();
        bus.I_fifo_full = 1'b1;
        for (int i = 1; i <= 4; i++) send(2'b00, 16'd0, 8'(i), 5'd0);
        bus.I_fifo_full = 1'b0;
        send(2'b00, 16'd0, 8'd5, 5'd0);
        step(10);
        check_val("t4_ovf",    bus.O_overflow, 0);
        check_val("t4_nwords", q_words.size(), 5);
        check_val("t4_w0",     q_words[0], 18'h00008);
        check_val("t4_w4",     q_words[4], 18'h00028);
        check_val("t4_count",  bus.O_word_count, 5);

        // clear in the same cycle as an overflow
        q_words.delete();
        bus.I_fifo_full = 1'b1;
        for (int i = 1; i <= 4; i++) send(2'b00, 16'd0, 8'(i), 5'd0);
        bus.I_clear_flags = 1'b1;
        send(2'b00, 16'd0, 8'd5, 5'd0);
        bus.I_clear_flags = 1'b0;
        bus.I_fifo_full   = 1'b0;
        check_val("t6_ovf",   bus.O_overflow,   0);
        check_val("t6_count", bus.O_word_count, 0);
        step(12);
        check_val("t6_nwords", q_words.size(), 4 + cMARK_WORDS);
`ifdef FE_PACKER_MARK_EN
        check_val("t6_mark",   q_words[4], 18'h30001);
`endif
        check_val("t6_count_end", bus.O_word_count, 4 + cMARK_WORDS);
        check_val("t6_ovf_end",   bus.O_overflow,   0);

        // reset with 3 words buffered
        q_words.delete();
        bus.I_fifo_full = 1'b1;
        for (int i = 1; i <= 3; i++) send(2'b00, 16'd0, 8'(i), 5'd0);
        #2;
        reset_i = 1'b1;
        #1;
        check_val("t5_wr",    bus.O_fifo_wr,    0);
        check_val("t5_din",   bus.O_fifo_din,   0);
        check_val("t5_ovf",   bus.O_overflow,   0);
        check_val("t5_count", bus.O_word_count, 0);
        step(1);
        bus.I_fifo_full = 1'b0;
        step(2);
        reset_i = 1'b0;
        step(10);
        check_val("t5_nwords",    q_words.size(),   0);
        check_val("t5_count_end", bus.O_word_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
